obi_rr_mux: RTL and testbench

OBI_RR_MUX -- requirements
Module: obi_rr_mux

---
 rtl/obi_rr_mux.sv | 121 ++++++++++++
 tb/tb_obi_rr_mux.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rr_mux.sv
// Round-robin OBI multiplexer: NMASTER masters share one slave, responses routed back
// in order through a small FIFO that also limits the number of outstanding transactions.
module obi_rr_mux #(
   parameter int unsigned NMASTER         = 3,
   parameter int unsigned MAX_OUTSTANDING = 2,
   localparam int unsigned IdxW = (NMASTER > 1) ? $clog2(NMASTER) : 1,
   localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NMASTER-1:0]      master_req_i,
   input  logic [NMASTER-1:0]      master_we_i,
   input  logic [4*NMASTER-1:0]    master_be_i,
   input  logic [32*NMASTER-1:0]   master_addr_i,
   input  logic [32*NMASTER-1:0]   master_wdata_i,
   output logic [NMASTER-1:0]      master_gnt_o,
   output logic [NMASTER-1:0]      master_rvalid_o,
   output logic [32*NMASTER-1:0]   master_rdata_o,
   output logic                    slave_req_o,
   output logic                    slave_we_o,
   output logic [3:0]              slave_be_o,
   output logic [31:0]             slave_addr_o,
   output logic [31:0]             slave_wdata_o,
   input  logic                    slave_gnt_i,
   input  logic                    slave_rvalid_i,
   input  logic [31:0]             slave_rdata_i,
   output logic [CntW-1:0]         outstanding_o,
   output logic                    rsp_err_o
);

   logic [IdxW-1:0] prio_q, lock_idx_q, sel;
   logic            lock_q, any_req, full, empty, accept, pop;
   logic [31:0]     cand;
   logic [IdxW-1:0] fifo_q [MAX_OUTSTANDING];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] count_q;

   assign full  = (count_q == CntW'(MAX_OUTSTANDING));
   assign empty = (count_q == '0);

   // A stalled request keeps the bus until accepted or withdrawn by its master.
   always_comb begin
      sel     = prio_q;
      any_req = 1'b0;
      cand    = '0;
      if (lock_q && master_req_i[lock_idx_q]) begin
         sel     = lock_idx_q;
         any_req = 1'b1;
      end else begin
         for (int unsigned i = 0; i < NMASTER; i++) begin
            cand = (32'(prio_q) + i) % NMASTER;
            if (!any_req && master_req_i[IdxW'(cand)]) begin
               any_req = 1'b1;
               sel     = IdxW'(cand);
            end
         end
      end
   end

   assign slave_req_o = rst_ni && any_req && !full;
   assign accept      = slave_req_o && slave_gnt_i;
   assign pop         = rst_ni && slave_rvalid_i && !empty;
   assign rsp_err_o   = rst_ni && slave_rvalid_i && empty;

   always_comb begin
      slave_we_o      = 1'b0;
      slave_be_o      = '0;
      slave_addr_o    = '0;
      slave_wdata_o   = '0;
      master_gnt_o    = '0;
      master_rvalid_o = '0;
      if (slave_req_o) begin
         slave_we_o    = master_we_i[sel];
         slave_be_o    = master_be_i[4*32'(sel) +: 4];
         slave_addr_o  = master_addr_i[32*32'(sel) +: 32];
         slave_wdata_o = master_wdata_i[32*32'(sel) +: 32];
         master_gnt_o[sel] = slave_gnt_i;
      end
      if (pop) begin
         master_rvalid_o[fifo_q[rptr_q]] = 1'b1;
      end
   end

   assign master_rdata_o = {NMASTER{slave_rdata_i}};
   assign outstanding_o  = count_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prio_q     <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
      end else begin
         lock_q     <= slave_req_o && !slave_gnt_i;
         lock_idx_q <= sel;
         if (accept) begin
            wptr_q <= (wptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PtrW'(1);
            prio_q <= (sel == IdxW'(NMASTER - 1)) ? '0 : sel + IdxW'(1);
         end
         if (pop) begin
            rptr_q <= (rptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PtrW'(1);
         end
         unique case ({accept, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; validity is tracked by the count and pointers.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         fifo_q[wptr_q] <= sel;
      end
   end

endmodule

// File: tb/tb_obi_rr_mux.sv
// Directed bench for obi_rr_mux (3 masters, 2 outstanding): arbitration, lock, full,
// push/pop ordering, spurious rvalid and reset behaviour.
module tb_obi_rr_mux;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic [2:0]   master_req_i, master_we_i;
   logic [11:0]  master_be_i;
   logic [95:0]  master_addr_i, master_wdata_i;
   logic [2:0]   master_gnt_o, master_rvalid_o;
   logic [95:0]  master_rdata_o;
   logic         slave_req_o, slave_we_o;
   logic [3:0]   slave_be_o;
   logic [31:0]  slave_addr_o, slave_wdata_o;
   logic         slave_gnt_i, slave_rvalid_i;
   logic [31:0]  slave_rdata_i;
   logic [1:0]   outstanding_o;
   logic         rsp_err_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   obi_rr_mux #(.NMASTER(3), .MAX_OUTSTANDING(2)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .master_req_i   (master_req_i),
      .master_we_i    (master_we_i),
      .master_be_i    (master_be_i),
      .master_addr_i  (master_addr_i),
      .master_wdata_i (master_wdata_i),
      .master_gnt_o   (master_gnt_o),
      .master_rvalid_o(master_rvalid_o),
      .master_rdata_o (master_rdata_o),
      .slave_req_o    (slave_req_o),
      .slave_we_o     (slave_we_o),
      .slave_be_o     (slave_be_o),
      .slave_addr_o   (slave_addr_o),
      .slave_wdata_o  (slave_wdata_o),
      .slave_gnt_i    (slave_gnt_i),
      .slave_rvalid_i (slave_rvalid_i),
      .slave_rdata_i  (slave_rdata_i),
      .outstanding_o  (outstanding_o),
      .rsp_err_o      (rsp_err_o)
   );

   function automatic logic [31:0] addr_of(input int m);
      return 32'h1000_0000 + 32'(m) * 32'h100;
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [2:0] req, input logic gnt, input logic rv);
      master_req_i   = req;
      slave_gnt_i    = gnt;
      slave_rvalid_i = rv;
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      drive(3'b111, 1'b1, 1'b1);
      checks++;
      if (slave_req_o !== 1'b0 || master_gnt_o !== 3'b000 || master_rvalid_o !== 3'b000) begin
         failures++;
         $display("FAIL reset_gate: req=%b gnt=%b rvalid=%b, want 0/000/000",
                  slave_req_o, master_gnt_o, master_rvalid_o);
      end
      checks++;
      if (slave_addr_o !== 32'h0 || slave_be_o !== 4'h0 || rsp_err_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_fields: addr=%h be=%h err=%b, want 0/0/0",
                  slave_addr_o, slave_be_o, rsp_err_o);
      end
      step();
      checks++;
      if (outstanding_o !== 2'd0) begin
         failures++;
         $display("FAIL reset_outstanding: got %0d want 0", outstanding_o);
      end
      drive(3'b000, 1'b0, 1'b0);
      rst_ni = 1'b1;
      step();
   endtask

   task automatic test_fairness();
      for (int k = 0; k <= 6; k++) begin
         slave_rdata_i = 32'hA000_0000 + 32'(k);
         drive((k < 6) ? 3'b111 : 3'b000, 1'b1, k > 0);
         checks++;
         if (k < 6) begin
            if (master_gnt_o !== 3'(1 << (k % 3)) || slave_addr_o !== addr_of(k % 3) ||
                slave_be_o !== 4'(1 << (k % 3)) || slave_we_o !== 1'((k % 3) & 1) ||
                slave_wdata_o !== 32'hC0DE_0000 + 32'(k % 3)) begin
               failures++;
               $display("FAIL rr_order[%0d]: gnt=%b addr=%h be=%h we=%b wdata=%h, want gnt=%b addr=%h",
                        k, master_gnt_o, slave_addr_o, slave_be_o, slave_we_o, slave_wdata_o,
                        3'(1 << (k % 3)), addr_of(k % 3));
            end
         end else if (slave_req_o !== 1'b0 || master_gnt_o !== 3'b000 || slave_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL rr_idle: req=%b gnt=%b addr=%h, want 0/000/0",
                     slave_req_o, master_gnt_o, slave_addr_o);
         end
         if (k > 0) begin
            checks++;
            if (master_rvalid_o !== 3'(1 << ((k - 1) % 3)) ||
                master_rdata_o[32 * ((k - 1) % 3) +: 32] !== slave_rdata_i) begin
               failures++;
               $display("FAIL rr_rvalid[%0d]: rvalid=%b rdata=%h, want %b %h", k,
                        master_rvalid_o, master_rdata_o[32 * ((k - 1) % 3) +: 32],
                        3'(1 << ((k - 1) % 3)), slave_rdata_i);
            end
         end
         checks++;
         if (outstanding_o !== ((k == 0) ? 2'd0 : 2'd1)) begin
            failures++;
            $display("FAIL rr_outstanding[%0d]: got %0d want %0d", k, outstanding_o,
                     (k == 0) ? 0 : 1);
         end
         step();
      end
      drive(3'b000, 1'b0, 1'b0);
      checks++;
      if (outstanding_o !== 2'd0) begin
         failures++;
         $display("FAIL rr_drain: got %0d want 0", outstanding_o);
      end
   endtask

   task automatic test_lock();
      for (int c = 0; c <= 4; c++) begin
         drive((c >= 2) ? 3'b101 : 3'b100, c == 4, 1'b0);
         checks++;
         if (slave_req_o !== 1'b1 || slave_addr_o !== addr_of(2) ||
             master_gnt_o !== ((c == 4) ? 3'b100 : 3'b000)) begin
            failures++;
            $display("FAIL lock_hold[%0d]: req=%b addr=%h gnt=%b, want 1 %h %b", c, slave_req_o,
                     slave_addr_o, master_gnt_o, addr_of(2), (c == 4) ? 3'b100 : 3'b000);
         end
         step();
      end
      drive(3'b101, 1'b1, 1'b0);
      checks++;
      if (master_gnt_o !== 3'b001 || slave_addr_o !== addr_of(0)) begin
         failures++;
         $display("FAIL lock_next: gnt=%b addr=%h, want 001 %h", master_gnt_o, slave_addr_o,
                  addr_of(0));
      end
      step();
      drive(3'b000, 1'b0, 1'b1);
      checks++;
      if (master_rvalid_o !== 3'b100 || outstanding_o !== 2'd2) begin
         failures++;
         $display("FAIL lock_rsp0: rvalid=%b out=%0d, want 100 2", master_rvalid_o, outstanding_o);
      end
      step();
      checks++;
      if (master_rvalid_o !== 3'b001 || outstanding_o !== 2'd1) begin
         failures++;
         $display("FAIL lock_rsp1: rvalid=%b out=%0d, want 001 1", master_rvalid_o, outstanding_o);
      end
      step();
      drive(3'b000, 1'b0, 1'b0);
   endtask

   task automatic test_full();
      // Expected per cycle: {req_in, rvalid_in, slave_req, gnt, rvalid, outstanding}
      logic [2:0] rq [7] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
      logic       rv [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic       sr [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0] eg [7] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};
      logic [2:0] er [7] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b010, 3'b010};
      logic [1:0] eo [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1};
      for (int c = 0; c < 7; c++) begin
         drive(rq[c], 1'b1, rv[c]);
         checks++;
         if (slave_req_o !== sr[c] || master_gnt_o !== eg[c] || master_rvalid_o !== er[c] ||
             outstanding_o !== eo[c]) begin
            failures++;
            $display("FAIL full[%0d]: req=%b gnt=%b rvalid=%b out=%0d, want %b %b %b %0d", c,
                     slave_req_o, master_gnt_o, master_rvalid_o, outstanding_o,
                     sr[c], eg[c], er[c], eo[c]);
         end
         step();
      end
      drive(3'b000, 1'b0, 1'b0);
      checks++;
      if (outstanding_o !== 2'd0) begin
         failures++;
         $display("FAIL full_drain: got %0d want 0", outstanding_o);
      end
   endtask

   task automatic test_push_pop();
      drive(3'b001, 1'b1, 1'b0);
      checks++;
      if (master_gnt_o !== 3'b001) begin
         failures++;
         $display("FAIL pp_first: gnt=%b want 001", master_gnt_o);
      end
      step();
      drive(3'b010, 1'b1, 1'b1);
      checks++;
      if (master_gnt_o !== 3'b010 || master_rvalid_o !== 3'b001 || outstanding_o !== 2'd1) begin
         failures++;
         $display("FAIL pp_same: gnt=%b rvalid=%b out=%0d, want 010 001 1",
                  master_gnt_o, master_rvalid_o, outstanding_o);
      end
      step();
      drive(3'b000, 1'b0, 1'b1);
      checks++;
      if (master_rvalid_o !== 3'b010 || outstanding_o !== 2'd1) begin
         failures++;
         $display("FAIL pp_after: rvalid=%b out=%0d, want 010 1", master_rvalid_o, outstanding_o);
      end
      step();
      drive(3'b000, 1'b0, 1'b0);
   endtask

   task automatic test_spurious();
      drive(3'b000, 1'b0, 1'b1);
      checks++;
      if (rsp_err_o !== 1'b1 || master_rvalid_o !== 3'b000 || outstanding_o !== 2'd0) begin
         failures++;
         $display("FAIL spurious: err=%b rvalid=%b out=%0d, want 1 000 0",
                  rsp_err_o, master_rvalid_o, outstanding_o);
      end
      step();
      drive(3'b000, 1'b0, 1'b0);
      checks++;
      if (rsp_err_o !== 1'b0 || outstanding_o !== 2'd0) begin
         failures++;
         $display("FAIL spurious_end: err=%b out=%0d, want 0 0", rsp_err_o, outstanding_o);
      end
   endtask

   task automatic test_reset_mid();
      drive(3'b100, 1'b1, 1'b0);
      step();
      drive(3'b010, 1'b1, 1'b0);
      step();
      rst_ni = 1'b0;
      drive(3'b101, 1'b1, 1'b1);
      checks++;
      if (outstanding_o !== 2'd2 || slave_req_o !== 1'b0 || master_rvalid_o !== 3'b000 ||
          rsp_err_o !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_pre: out=%0d req=%b rvalid=%b err=%b, want 2 0 000 0",
                  outstanding_o, slave_req_o, master_rvalid_o, rsp_err_o);
      end
      step();
      rst_ni = 1'b1;
      drive(3'b000, 1'b0, 1'b1);
      checks++;
      if (outstanding_o !== 2'd0 || rsp_err_o !== 1'b1 || master_rvalid_o !== 3'b000) begin
         failures++;
         $display("FAIL rstmid_post: out=%0d err=%b rvalid=%b, want 0 1 000",
                  outstanding_o, rsp_err_o, master_rvalid_o);
      end
      step();
      drive(3'b101, 1'b1, 1'b0);
      checks++;
      if (master_gnt_o !== 3'b001 || slave_addr_o !== addr_of(0)) begin
         failures++;
         $display("FAIL rstmid_prio: gnt=%b addr=%h, want 001 %h", master_gnt_o, slave_addr_o,
                  addr_of(0));
      end
      step();
      drive(3'b000, 1'b0, 1'b1);
      checks++;
      if (master_rvalid_o !== 3'b001 || rsp_err_o !== 1'b0 || outstanding_o !== 2'd1) begin
         failures++;
         $display("FAIL rstmid_rsp: rvalid=%b err=%b out=%0d, want 001 0 1",
                  master_rvalid_o, rsp_err_o, outstanding_o);
      end
      step();
      drive(3'b000, 1'b0, 1'b0);
   endtask

   initial begin
      for (int m = 0; m < 3; m++) begin
         master_addr_i[32 * m +: 32]  = addr_of(m);
         master_wdata_i[32 * m +: 32] = 32'hC0DE_0000 + 32'(m);
         master_be_i[4 * m +: 4]      = 4'(1 << m);
         master_we_i[m]               = 1'(m & 1);
      end
      rst_ni         = 1'b0;
      master_req_i   = '0;
      slave_gnt_i    = 1'b0;
      slave_rvalid_i = 1'b0;
      slave_rdata_i  = '0;
      step();
      test_reset();
      test_fairness();
      test_lock();
      test_full();
      test_push_pop();
      test_spurious();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
